// File: rtl/batcharger_adc_scheduler_if.sv
// Handshake between the ADC scheduler (master) and the shared 8-bit SAR ADC front end (slave).
interface batcharger_adc_scheduler_if;
  logic [1:0] adc_sel;
  logic       adc_start;
  logic       adc_done;
  logic [7:0] adc_data;

  modport master (output adc_sel, output adc_start, input adc_done, input adc_data);
  modport slave  (input adc_sel, input adc_start, output adc_done, output adc_data);
endinterface

// File: rtl/batcharger_adc_scheduler.sv
// Round-robin V/I/T sampling scheduler for one shared SAR ADC.
// Optional BATCHARGER_ADC_AVG_EN: captures are averaged with the previous valid code.
//   state   | meaning
//   IDLE    | no request or block disabled, adc_sel=11
//   SELECT  | pick next enabled channel after the last serviced one
//   SETTLE  | mux settling, counter counts down to 0
//   CONVERT | start pulse on first cycle, wait for done or timeout
module batcharger_adc_scheduler #(
  parameter int SETTLE_CYC  = 4,
  parameter int TIMEOUT_CYC = 200
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic       vmonen,
  input  logic       imonen,
  input  logic       tmonen,
  batcharger_adc_scheduler_if.master adc,
  output logic [7:0] vbat,
  output logic [7:0] ibat,
  output logic [7:0] tbat,
  output logic       vtok,
  output logic [2:0] adc_err
);

  typedef enum logic [1:0] {ST_IDLE, ST_SELECT, ST_SETTLE, ST_CONVERT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      ch_q, ch_d;
  logic [1:0]      rr_q, rr_d;
  logic [2:0][7:0] data_q, data_d;
  logic [2:0]      valid_q, valid_d;
  logic [2:0]      err_q, err_d;
  logic            vtok_q, vtok_d;

  logic [2:0] mon;
  logic [2:0] rot;
  logic [1:0] off;
  logic [2:0] psum;
  logic [1:0] pick;
  logic       pick_ok;
  logic [1:0] ch_next;
  logic [7:0] new_code;
  logic [1:0] sel_c;
  logic       start_c;

  assign mon = {tmonen, imonen, vmonen};

  // Rotate the request mask so bit 0 is the channel with current priority.
  always_comb begin
    rot = mon;
    case (rr_q)
      2'd1:    rot = {mon[0], mon[2], mon[1]};
      2'd2:    rot = {mon[1], mon[0], mon[2]};
      default: rot = mon;
    endcase
    off = 2'd0;
    if (rot[0])      off = 2'd0;
    else if (rot[1]) off = 2'd1;
    else             off = 2'd2;
    pick_ok = |rot;
    psum    = {1'b0, rr_q} + {1'b0, off};
    pick    = (psum >= 3'd3) ? 2'(psum - 3'd3) : psum[1:0];
  end

  assign ch_next = (ch_q == 2'd2) ? 2'd0 : ch_q + 2'd1;

`ifdef BATCHARGER_ADC_AVG_EN
  logic [8:0] avg_sum;
  assign avg_sum  = {1'b0, data_q[ch_q]} + {1'b0, adc.adc_data} + 9'd1;
  assign new_code = valid_q[ch_q] ? avg_sum[8:1] : adc.adc_data;
`else
  assign new_code = adc.adc_data;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ch_d    = ch_q;
    rr_d    = rr_q;
    data_d  = data_q;
    valid_d = valid_q & mon;
    err_d   = err_q;
    vtok_d  = valid_q[0] & valid_q[2];
    sel_c   = 2'b11;
    start_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && (|mon)) state_d = ST_SELECT;
      end
      ST_SELECT: begin
        if (pick_ok) begin
          sel_c   = pick;
          ch_d    = pick;
          cnt_d   = 8'(SETTLE_CYC - 1);
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        sel_c = ch_q;
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd1;
          state_d = ST_CONVERT;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_CONVERT: begin
        sel_c   = ch_q;
        start_c = (cnt_q == 8'd1);
        // Done beats a same-cycle timeout; a dropped channel discards its result.
        if ((cnt_q != 8'd1) && adc.adc_done) begin
          if (mon[ch_q]) begin
            data_d[ch_q]  = new_code;
            valid_d[ch_q] = 1'b1;
          end
          rr_d    = ch_next;
          state_d = ST_SELECT;
        end else if (cnt_q == 8'(TIMEOUT_CYC)) begin
          err_d[ch_q]   = 1'b1;
          valid_d[ch_q] = 1'b0;
          rr_d          = ch_next;
          state_d       = ST_SELECT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!en) begin
      state_d = ST_IDLE;
      valid_d = 3'b000;
      err_d   = 3'b000;
      start_c = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      state_q <= ST_IDLE;
      cnt_q   <= 8'd0;
      ch_q    <= 2'd0;
      rr_q    <= 2'd0;
      data_q  <= '0;
      valid_q <= 3'b000;
      err_q   <= 3'b000;
      vtok_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      vtok_q  <= vtok_d;
    end
  end

  assign adc.adc_sel   = sel_c;
  assign adc.adc_start = start_c;
  assign vbat          = data_q[0];
  assign ibat          = data_q[1];
  assign tbat          = data_q[2];
  assign vtok          = vtok_q;
  assign adc_err       = err_q;

endmodule

// File: tb/tb_batcharger_adc_scheduler.sv
// Self-checking bench: directed scenarios plus randomized conversions vs a transaction-level model.
module tb_batcharger_adc_scheduler;
  localparam int SETTLE = 4;
  localparam int TMO    = 200;

  logic clk, rstz, en, vmonen, imonen, tmonen;
  logic [7:0] vbat, ibat, tbat;
  logic vtok;
  logic [2:0] adc_err;

  batcharger_adc_scheduler_if adc_if ();

  batcharger_adc_scheduler #(.SETTLE_CYC(SETTLE), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rstz(rstz), .en(en),
    .vmonen(vmonen), .imonen(imonen), .tmonen(tmonen),
    .adc(adc_if.master),
    .vbat(vbat), .ibat(ibat), .tbat(tbat), .vtok(vtok), .adc_err(adc_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  // Reference model: channel codes, valid flags, sticky errors, last serviced channel.
  logic [2:0] mask;
  logic [7:0] m_reg[3];
  bit         m_valid[3];
  logic [2:0] m_err;
  int         last;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_reg[i]   = 8'h00;
      m_valid[i] = 1'b0;
    end
    m_err = 3'b000;
    last  = 2;
  endtask

  task automatic apply_mask(input logic [2:0] m);
    for (int i = 0; i < 3; i++) if (!m[i]) m_valid[i] = 1'b0;
    mask = m;
    {tmonen, imonen, vmonen} = m;
  endtask

  function automatic int next_ch();
    int c;
    for (int k = 1; k <= 3; k++) begin
      c = (last + k) % 3;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic wait_start(input int exp_ch, input int exp_wait);
    int n;
    n = 0;
    while (adc_if.adc_start !== 1'b1 && n < 400) begin
      cycle();
      n++;
    end
    if (n >= 400) begin
      check("start_wait_expired", 32'd0, 32'd1);
      $display("%0d/%0d checks passed", passed, total);
      $fatal(1, "bench aborted: no adc_start");
    end
    if (exp_wait >= 0) check("start_latency", n, exp_wait);
    check("adc_sel", adc_if.adc_sel, exp_ch);
  endtask

  // One conversion: wait start, respond (or time out), update model, check codes/err/vtok.
  task automatic run_conv(input int lat, input logic [7:0] data, input bit tmo,
                          input bit drop, input bit glitch, input int exp_wait,
                          input logic [2:0] nmask);
    int ch;
    bit vt;
    ch = next_ch();
    wait_start(ch, exp_wait);
    if (glitch) begin
      adc_if.adc_done = 1'b1;
      adc_if.adc_data = ~data;
    end
    if (drop) begin
      logic [2:0] m;
      m = mask;
      m[ch] = 1'b0;
      apply_mask(m);
    end
    if (tmo) begin
      for (int k = 0; k < TMO; k++) begin
        cycle();
        adc_if.adc_done = 1'b0;
      end
    end else begin
      for (int k = 0; k < lat; k++) begin
        cycle();
        adc_if.adc_done = 1'b0;
      end
      adc_if.adc_done = 1'b1;
      adc_if.adc_data = data;
      cycle();
      adc_if.adc_done = 1'b0;
    end
    last = ch;
    if (tmo) begin
      m_err[ch]   = 1'b1;
      m_valid[ch] = 1'b0;
    end else if (mask[ch]) begin
`ifdef BATCHARGER_ADC_AVG_EN
      if (m_valid[ch]) m_reg[ch] = 8'((int'(m_reg[ch]) + int'(data) + 1) / 2);
      else m_reg[ch] = data;
`else
      m_reg[ch] = data;
`endif
      m_valid[ch] = 1'b1;
    end
    check("vbat", vbat, m_reg[0]);
    check("ibat", ibat, m_reg[1]);
    check("tbat", tbat, m_reg[2]);
    check("adc_err", adc_err, m_err);
    vt = m_valid[0] & m_valid[2];
    apply_mask(nmask);
    cycle();
    check("vtok", vtok, vt);
  endtask

  initial begin
    int starts;
    rstz = 1'b0; en = 1'b0; mask = 3'b000;
    vmonen = 1'b0; imonen = 1'b0; tmonen = 1'b0;
    adc_if.adc_done = 1'b0; adc_if.adc_data = 8'h00;
    model_reset();
    repeat (2) cycle();
    check("rst_sel", adc_if.adc_sel, 2'b11);
    check("rst_start", adc_if.adc_start, 1'b0);
    check("rst_vbat", {vbat, ibat, tbat}, 24'h0);
    check("rst_vtok", vtok, 1'b0);
    check("rst_err", adc_err, 3'b000);
    rstz = 1'b1;
    cycle();

    // V and T only
    apply_mask(3'b101);
    en = 1'b1;
    run_conv(3, 8'h93, 0, 0, 0, SETTLE + 2, 3'b101);
    run_conv(3, 8'h40, 0, 0, 0, SETTLE, 3'b101);
    run_conv(3, 8'h93, 0, 0, 0, SETTLE, 3'b111);

    // all three channels
    run_conv(3, 8'h02, 0, 0, 0, SETTLE, 3'b111);
    run_conv(5, 8'h31, 0, 0, 0, SETTLE, 3'b111);
    run_conv(2, 8'h93, 0, 0, 0, SETTLE, 3'b111);
    run_conv(4, 8'h05, 0, 0, 0, SETTLE, 3'b101);

    // timeout on V, then done coinciding with timeout on T
    run_conv(3, 8'h44, 0, 0, 0, SETTLE, 3'b101);
    run_conv(0, 8'h00, 1, 0, 0, SETTLE, 3'b101);
    run_conv(TMO - 1, 8'h66, 0, 0, 1, SETTLE, 3'b101);
    run_conv(1, 8'h12, 0, 0, 1, SETTLE, 3'b111);

    // monen drop mid-conversion
    run_conv(3, 8'hAA, 0, 1, 0, SETTLE, 3'b111);

    // en drop during SETTLE
    en = 1'b0;
    for (int i = 0; i < 3; i++) m_valid[i] = 1'b0;
    m_err = 3'b000;
    cycle();
    check("endrop_sel", adc_if.adc_sel, 2'b11);
    check("endrop_start", adc_if.adc_start, 1'b0);
    check("endrop_err", adc_err, 3'b000);
    check("endrop_vbat", vbat, m_reg[0]);
    cycle();
    check("endrop_vtok", vtok, 1'b0);
    starts = 0;
    for (int i = 0; i < 8; i++) begin
      if (adc_if.adc_start === 1'b1) starts++;
      cycle();
    end
    check("endrop_no_start", starts, 0);
    en = 1'b1;
    run_conv(3, 8'h21, 0, 0, 0, SETTLE + 2, 3'b111);

    // async reset mid-CONVERT with adc_done high
    wait_start(next_ch(), SETTLE);
    cycle();
    adc_if.adc_done = 1'b1;
    adc_if.adc_data = 8'h55;
    #2 rstz = 1'b0;
    #1;
    check("arst_sel", adc_if.adc_sel, 2'b11);
    check("arst_start", adc_if.adc_start, 1'b0);
    check("arst_codes", {vbat, ibat, tbat}, 24'h0);
    check("arst_vtok", vtok, 1'b0);
    check("arst_err", adc_err, 3'b000);
    en = 1'b0;
    cycle();
    adc_if.adc_done = 1'b0;
    rstz = 1'b1;
    model_reset();
    cycle();
    check("arst_nocap", {vbat, ibat, tbat}, 24'h0);

    // V 0x80 then 0x91 (averaged when the option is built in)
    apply_mask(3'b001);
    en = 1'b1;
    run_conv(3, 8'h80, 0, 0, 0, SETTLE + 2, 3'b001);
    run_conv(3, 8'h91, 0, 0, 0, SETTLE, 3'b111);

    // randomized conversions
    for (int it = 0; it < 30; it++) begin
      logic [2:0] nm;
      int lat;
      logic [7:0] d;
      bit drop, glitch, tmo;
      nm     = 3'($urandom_range(1, 7));
      lat    = $urandom_range(1, 12);
      d      = 8'($urandom);
      drop   = ($urandom_range(0, 7) == 0);
      glitch = $urandom_range(0, 1) != 0;
      tmo    = ($urandom_range(0, 14) == 0);
      run_conv(lat, d, tmo, drop, glitch, SETTLE, nm);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/batcharger_adc_scheduler.md
Name: batcharger_adc_scheduler

Overview:
- Shares one 8-bit SAR ADC between the three battery monitor channels: voltage (V), current (I) and temperature (T).
- Sits between the charger FSM and the analog front end.
- Takes the per-channel monitor enables (vmonen/imonen/tmonen) from the controller and sequences the mux select, settle and conversion handshake for each channel.
- Holds the latest vbat/ibat/tbat codes and generates vtok for the controller.

Parameters:
- SETTLE_CYC, 4: mux settle cycles before each conversion start; legal range 1..255.
- TIMEOUT_CYC, 200: max CONVERT cycles waiting for adc_done before the conversion is aborted; legal range 2..255.

Ports:
- clk  input  1  state machine clock
- rstz  input  1  asynchronous active-low reset
- en  input  1  block enable
- vmonen  input  1  request V channel sampling
- imonen  input  1  request I channel sampling
- tmonen  input  1  request T channel sampling
- adc_sel  output  2  mux select: 00=V, 01=I, 10=T, 11=idle
- adc_start  output  1  one-cycle conversion start pulse
- adc_done  input  1  conversion complete; qualifies adc_data
- adc_data  input  8  ADC result
- vbat  output  8  latest V code
- ibat  output  8  latest I code
- tbat  output  8  latest T code
- vtok  output  1  V and T codes both valid
- adc_err  output  3  sticky timeout flags {T,I,V}

Behaviour:
- Reset (rstz low, asynchronous):
  - state=IDLE, adc_sel=11, adc_start=0.
  - vbat=ibat=tbat=0, vtok=0, adc_err=0.
  - Valid flags cleared. Round-robin pointer set to V.
- States and transitions:
  - IDLE: adc_sel=11. If en=1 and any monen=1, go to SELECT.
  - SELECT (1 cycle): choose the first enabled channel in the cyclic order V→I→T, starting after the last serviced channel.
    - Drive adc_sel for that channel; it is held through SETTLE and CONVERT.
    - Load the counter with SETTLE_CYC-1 and go to SETTLE.
    - If no channel is enabled, return to IDLE.
  - SETTLE: decrement the counter. At 0, go to CONVERT.
  - CONVERT:
    - adc_start=1 on the first CONVERT cycle only; adc_done is ignored in that cycle.
    - Counter counts up from 1.
    - adc_done=1: capture adc_data into the channel register at that edge, set its valid flag, update the round-robin pointer, go to SELECT.
    - Counter reaches TIMEOUT_CYC with no adc_done: set adc_err[ch], clear the valid flag, leave the register unchanged, update the pointer, go to SELECT.
- Latency: adc_start occurs SETTLE_CYC+1 cycles after entering SELECT. The captured code is visible on vbat/ibat/tbat the cycle after adc_done.
- vtok: registered, equal to v_valid & t_valid. It updates one cycle after a flag changes.
- en deassertion (any state): next edge goes to IDLE, adc_start=0, all valid flags and adc_err cleared, vtok=0 the following cycle. Data registers hold their values.
- monen deassertion:
  - The channel's valid flag clears on the next edge.
  - If that channel is mid-conversion, the conversion runs to done or timeout, but the result is discarded and the flag stays clear.
- adc_done outside CONVERT: ignored.
- Simultaneous adc_done and timeout in the same cycle: done wins (data captured, no error).
- Priority between channels is strictly round-robin. With all three enabled the order is V, I, T, V, ...

Optional Feature:
- Macro: BATCHARGER_ADC_AVG_EN.
- Defined:
  - Each capture stores (old + adc_data + 1) >> 1 using 9-bit intermediate arithmetic.
  - The first capture after valid=0 stores adc_data raw.
- Undefined: raw adc_data is stored on every capture.

Test Plan:
- Only vmonen=1 and tmonen=1, SETTLE_CYC=4, adc_done 3 cycles after each start with data V=0x93, T=0x40:
  - adc_sel sequence 00,10,00,...
  - adc_start 5 cycles after SELECT.
  - vbat=0x93, tbat=0x40.
  - vtok=1 one cycle after the T capture.
- All three monen=1: adc_sel order 00,01,10,00. ibat captures 0x02 when the I conversion returns 0x02.
- adc_done is never returned, TIMEOUT_CYC=200:
  - adc_err[0]=1 after 200 CONVERT cycles.
  - vbat holds its prior value 0x93.
  - Scheduler moves on to T.
- en dropped during SETTLE:
  - Next edge IDLE, adc_sel=11, no adc_start.
  - vtok=0 and adc_err=000.
  - vbat unchanged.
- rstz pulsed low mid-CONVERT with adc_done high: outputs are immediately at reset values and no capture occurs.
- BATCHARGER_ADC_AVG_EN defined, V samples 0x80 then 0x91: vbat=0x80, then 0x89.
